instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage between the program counter and the control unit.
//  Holds the program in a loadable 64x32 instruction memory and fetches the word at the PC's instruction_address.
//  Presents the word to the control unit with a valid/ack handshake, pulses pc_inc to advance the PC, and detects HALT.
//  halt drives the PC's complete input.
// PARAMETERS
//  ADDR_W   6      instruction address width (matches PC output)
//  INSTR_W  32     instruction word width
//  DEPTH    64     memory words (2**ADDR_W)
//  HALT_OP  8'hFF  opcode in instruction[31:24] that stops fetching
// PORTS
//  clk                  in   1        single clock; all state changes on posedge
//  rst                  in   1        asynchronous, active-high reset
//  load_en              in   1        program-load write strobe
//  load_addr            in   ADDR_W   program-load address
//  load_data            in   INSTR_W  program-load word
//  instruction_address  in   ADDR_W   current PC value
//  fetch_req            in   1        control unit requests the next instruction (level)
//  instr_ack            in   1        control unit consumed the instruction
//  flush                in   1        abort an in-flight fetch (branch/PC write)
//  instruction          out  INSTR_W  fetched instruction word, held while instr_valid=1
//  instr_valid          out  1        instruction is valid
//  pc_inc               out  1        one-cycle pulse to the PC inc input
//  halt                 out  1        sticky; HALT fetched
// BEHAVIOUR
//  Reset (async): state=IDLE; instruction=0; instr_valid=0; pc_inc=0; halt=0.
//   Memory contents are NOT cleared.
//  All outputs are registered.
//  FSM states: IDLE, READ, VALID, ADV.
//  IDLE:
//   - load_en=1: mem[load_addr]<=load_data; stay in IDLE. Load wins over a simultaneous fetch_req.
//   - else fetch_req=1 and halt=0: rdata<=mem[instruction_address]; go to READ.
//   - fetch_req is ignored while halt=1.
//  READ: instruction<=rdata; instr_valid<=1; go to VALID.
//   If rdata[31:24]==HALT_OP, halt<=1 at the same edge.
//  VALID: hold instruction and instr_valid until instr_ack=1. On ack: instr_valid<=0.
//   - If halt=1: go to IDLE (no pc_inc).
//   - Otherwise: pc_inc<=1 and go to ADV.
//  ADV: pc_inc<=0; go to IDLE.
//   This guarantees the PC has incremented before IDLE samples the address again.
//  Latency: fetch_req sampled at edge k -> instr_valid=1 after edge k+1.
//   Minimum fetch-to-fetch spacing is 4 cycles.
//  flush=1 in READ or VALID: instr_valid<=0; no pc_inc; go to IDLE. flush takes priority over instr_ack.
//   flush in IDLE or ADV has no effect; a pc_inc already issued completes.
//  load_en outside IDLE is ignored (no write).
//  instr_ack outside VALID is ignored.
//  halt clears only on rst.
//  Address wrap: no wrap logic here; the address comes from the PC (63+1 -> 0 is the PC's wrap).
//  Reset mid-fetch: everything returns to the reset values immediately; a pending pc_inc is dropped.
//  The PC may be written only while this block is in IDLE; the control unit asserts flush with any PC write.
// STRUCTURE
//  Shared package proc_pkg: ADDR_W, INSTR_W, HALT_OP, opcode field slice [31:24], fetch FSM state encoding.
//  Sub-module instr_mem: DEPTH x INSTR_W, synchronous write, synchronous read, single port.
//   Write has priority; no reset on the array.
//  Top: FSM, output registers, halt detect.
// TESTING
//  1. Load mem[0]=32'h0100_0001, mem[1]=32'h0200_0002; PC=0; hold fetch_req.
//     -> instruction=32'h0100_0001 with instr_valid after 2 edges; ack -> one pc_inc pulse; next word is 32'h0200_0002.
//  2. Hold instr_ack=0 for 5 cycles in VALID -> instruction and instr_valid are stable, pc_inc=0 throughout.
//  3. mem[2]=32'hFF00_0000; fetch at PC=2 -> halt=1 when instr_valid rises; ack gives no pc_inc;
//     further fetch_req is ignored until rst.
//  4. flush in READ, and flush together with instr_ack in VALID -> instr_valid=0, no pc_inc, state IDLE.
//  5. load_en and fetch_req together in IDLE -> write happens, no fetch that cycle;
//     load_en during VALID -> memory unchanged (read back to confirm).
//  6. Assert rst asynchronously during VALID and during ADV -> all outputs 0 immediately;
//     memory contents are preserved after reset.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: widths, HALT opcode and fetch FSM encoding.
package proc_pkg;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [7:0] HALT_OP = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        VALID,
        ADV
    } fetch_state_t;

    function automatic logic [7:0] opcode(input logic [INSTR_W-1:0] word);
        return word[31:24];
    endfunction
endpackage

// File: rtl/instr_mem.sv
// Single-port program memory; a write in the same cycle suppresses the read.
module instr_mem
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [INSTR_W-1:0] wdata,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the word at the PC, hands it over with valid/ack,
// pulses pc_inc after each consumed word and latches HALT.
module instr_fetch_unit
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W-1:0]  instruction_address,
    input  logic               fetch_req,
    input  logic               instr_ack,
    input  logic               flush,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic               pc_inc,
    output logic               halt
);
    fetch_state_t       state, state_n;
    logic [INSTR_W-1:0] instr_n;
    logic               valid_n, inc_n, halt_n;
    logic               we, re;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] rdata;

    instr_mem u_mem (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (mem_addr),
        .wdata (load_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc_inc      <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state       <= state_n;
            instruction <= instr_n;
            instr_valid <= valid_n;
            pc_inc      <= inc_n;
            halt        <= halt_n;
        end
    end

    always_comb begin
        state_n  = state;
        instr_n  = instruction;
        valid_n  = instr_valid;
        inc_n    = 1'b0;
        halt_n   = halt;
        we       = 1'b0;
        re       = 1'b0;
        mem_addr = instruction_address;
        unique case (state)
            IDLE: begin
                if (load_en) begin
                    we       = 1'b1;
                    mem_addr = load_addr;
                end else if (fetch_req && !halt) begin
                    re      = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                if (flush) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    instr_n = rdata;
                    valid_n = 1'b1;
                    state_n = VALID;
                    if (opcode(rdata) == HALT_OP)
                        halt_n = 1'b1;
                end
            end
            VALID: begin
                // flush outranks ack so an aborted word never advances the PC
                if (flush) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (instr_ack) begin
                    valid_n = 1'b0;
                    if (halt) begin
                        state_n = IDLE;
                    end else begin
                        inc_n   = 1'b1;
                        state_n = ADV;
                    end
                end
            end
            ADV: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table plus corner sequences.
module tb_instr_fetch_unit;
    import proc_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_req;
    logic               instr_ack;
    logic               flush;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               pc_inc;
    logic               halt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } vec_t;

    vec_t               vecs [7];
    logic [INSTR_W-1:0] model [DEPTH];
    logic [INSTR_W-1:0] exp_q [$];

    instr_fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_en             (load_en),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .instruction_address (pc),
        .fetch_req           (fetch_req),
        .instr_ack           (instr_ack),
        .flush               (flush),
        .instruction         (instruction),
        .instr_valid         (instr_valid),
        .pc_inc              (pc_inc),
        .halt                (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // PC model: advances whenever the DUT pulses pc_inc
    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_inc === 1'b1)
            pc = pc + 1'b1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
        model[a]  = d;
    endtask

    task automatic start_fetch(input string name);
        int lat;
        logic [INSTR_W-1:0] exp;
        lat = 0;
        fetch_req = 1'b1;
        exp_q.push_back(model[pc]);
        while (instr_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        fetch_req = 1'b0;
        exp = exp_q.pop_front();
        check({name, " valid"}, 32'(instr_valid), 32'd1);
        check({name, " latency"}, lat, 2);
        check({name, " word"}, instruction, exp);
    endtask

    task automatic finish_ack(input string name, input logic exp_inc);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        check({name, " valid drop"}, 32'(instr_valid), 32'd0);
        check({name, " pc_inc"}, 32'(pc_inc), 32'(exp_inc));
        tick();
        check({name, " pc_inc end"}, 32'(pc_inc), 32'd0);
    endtask

    initial begin
        vecs[0] = '{6'd0, 32'h0100_0001};
        vecs[1] = '{6'd1, 32'h0200_0002};
        vecs[2] = '{6'd2, 32'h3300_1234};
        vecs[3] = '{6'd3, 32'h44AB_CDEF};
        vecs[4] = '{6'd4, 32'h0000_0000};
        vecs[5] = '{6'd5, 32'hFE00_FFFF};
        vecs[6] = '{6'd6, 32'h1234_5678};

        rst = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        pc = '0;
        fetch_req = 1'b0;
        instr_ack = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        check("reset instruction", instruction, 32'd0);
        check("reset valid", 32'(instr_valid), 32'd0);
        check("reset pc_inc", 32'(pc_inc), 32'd0);
        check("reset halt", 32'(halt), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) load(vecs[i].addr, vecs[i].data);

        // sequential fetch through the table, PC driven by pc_inc
        pc = '0;
        for (int i = 0; i < 6; i++) begin
            start_fetch($sformatf("vec%0d", i));
            finish_ack($sformatf("vec%0d", i), 1'b1);
            check($sformatf("vec%0d pc", i), 32'(pc), 32'(i + 1));
        end

        // stall in VALID
        start_fetch("stall");
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d hold", c),
                  {instruction[30:0], instr_valid}, {vecs[6].data[30:0], 1'b1});
            check($sformatf("stall%0d pc_inc", c), 32'(pc_inc), 32'd0);
        end
        finish_ack("stall", 1'b1);

        // flush in READ
        pc = 6'd0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush READ valid", 32'(instr_valid), 32'd0);
        check("flush READ pc_inc", 32'(pc_inc), 32'd0);
        tick();
        check("flush READ idle", {31'd0, instr_valid | pc_inc}, 32'd0);

        // flush with ack in VALID
        start_fetch("flushv");
        flush = 1'b1;
        instr_ack = 1'b1;
        tick();
        flush = 1'b0;
        instr_ack = 1'b0;
        check("flush VALID valid", 32'(instr_valid), 32'd0);
        check("flush VALID pc_inc", 32'(pc_inc), 32'd0);
        tick();
        check("flush VALID pc_inc2", 32'(pc_inc), 32'd0);
        check("flush VALID pc", 32'(pc), 32'd0);
        start_fetch("post flush");
        finish_ack("post flush", 1'b1);

        // load wins over fetch in IDLE
        pc = 6'd10;
        load_en = 1'b1;
        load_addr = 6'd10;
        load_data = 32'hAAAA_5555;
        fetch_req = 1'b1;
        tick();
        load_en = 1'b0;
        fetch_req = 1'b0;
        model[10] = 32'hAAAA_5555;
        tick();
        check("load+fetch no read", 32'(instr_valid), 32'd0);
        tick();
        check("load+fetch no valid", 32'(instr_valid), 32'd0);
        start_fetch("load readback");
        // load during VALID must be ignored
        load_en = 1'b1;
        load_addr = 6'd10;
        load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        check("load in VALID hold", 32'(instr_valid), 32'd1);
        finish_ack("load readback", 1'b1);
        pc = 6'd10;
        start_fetch("ignored load");
        finish_ack("ignored load", 1'b1);

        // HALT
        load(6'd2, 32'hFF00_0000);
        pc = 6'd2;
        start_fetch("halt");
        check("halt set", 32'(halt), 32'd1);
        finish_ack("halt", 1'b0);
        check("halt pc", 32'(pc), 32'd2);
        fetch_req = 1'b1;
        repeat (4) tick();
        fetch_req = 1'b0;
        check("halt blocks fetch", 32'(instr_valid), 32'd0);
        check("halt sticky", 32'(halt), 32'd1);

        // async reset during VALID
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        check("halt cleared", 32'(halt), 32'd0);
        pc = 6'd1;
        start_fetch("rst valid");
        #2;
        rst = 1'b1;
        #1;
        check("rst VALID instruction", instruction, 32'd0);
        check("rst VALID valid", 32'(instr_valid), 32'd0);
        check("rst VALID halt", 32'(halt), 32'd0);
        rst = 1'b0;
        tick();

        // async reset during ADV
        pc = 6'd3;
        start_fetch("rst adv");
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        check("adv pc_inc", 32'(pc_inc), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst ADV pc_inc", 32'(pc_inc), 32'd0);
        rst = 1'b0;
        tick();
        check("rst ADV after", {31'd0, pc_inc | instr_valid}, 32'd0);

        // memory survives reset
        pc = 6'd0;
        start_fetch("mem kept");
        finish_ack("mem kept", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
